// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with registered read data and full/empty flags.
//               Optional sticky overflow/underflow flags under SYNC_FIFO_ERR_EN.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    wr_en,
    input  logic [WIDTH-1:0]        data_in,
    input  logic                    rd_en,
    output logic [WIDTH-1:0]        data_out,
    output logic                    full,
    output logic                    empty,
`ifdef SYNC_FIFO_ERR_EN
    output logic                    overflow,
    output logic                    underflow,
`endif
    output logic [$clog2(DEPTH):0]  count
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] c_full_cnt = (AW+1)'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [AW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [AW:0]      count_q, count_d;
    logic [WIDTH-1:0] data_out_q, data_out_d;
    logic             w_wr_acc;
    logic             w_rd_acc;

    // Accept decisions use the flags as they stand before the edge.
    assign w_wr_acc = wr_en && (count_q != c_full_cnt);
    assign w_rd_acc = rd_en && (count_q != '0);

    always_comb begin
        wr_ptr_d   = wr_ptr_q;
        rd_ptr_d   = rd_ptr_q;
        count_d    = count_q;
        data_out_d = data_out_q;
        if (w_wr_acc) begin
            wr_ptr_d = wr_ptr_q + AW'(1);
        end
        if (w_rd_acc) begin
            rd_ptr_d   = rd_ptr_q + AW'(1);
            data_out_d = mem_q[rd_ptr_q];
        end
        case ({w_wr_acc, w_rd_acc})
            2'b10:   count_d = count_q + (AW+1)'(1);
            2'b01:   count_d = count_q - (AW+1)'(1);
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            count_q    <= count_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage has no reset; contents are only meaningful between the pointers.
    always_ff @(posedge clk) begin
        if (rst_n && w_wr_acc) begin
            mem_q[wr_ptr_q] <= data_in;
        end
    end

`ifdef SYNC_FIFO_ERR_EN
    logic overflow_q;
    logic underflow_q;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            overflow_q  <= 1'b0;
            underflow_q <= 1'b0;
        end else begin
            if (wr_en && (count_q == c_full_cnt)) overflow_q  <= 1'b1;
            if (rd_en && (count_q == '0))         underflow_q <= 1'b1;
        end
    end

    assign overflow  = overflow_q;
    assign underflow = underflow_q;
`endif

    assign data_out = data_out_q;
    assign count    = count_q;
    assign full     = (count_q == c_full_cnt);
    assign empty    = (count_q == '0);

endmodule
`default_nettype wire
